// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: ALU op codes, FSM state
// encodings, byte-enable base masks and op classification helpers.
package lsu_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // ALU op codes shared with the execute stage
    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd1;
    localparam logic [5:0] ALU_AND  = 6'd2;
    localparam logic [5:0] ALU_OR   = 6'd3;
    localparam logic [5:0] ALU_XOR  = 6'd4;
    localparam logic [5:0] ALU_SLL  = 6'd5;
    localparam logic [5:0] ALU_SRL  = 6'd6;
    localparam logic [5:0] ALU_SRA  = 6'd7;
    localparam logic [5:0] ALU_SLT  = 6'd8;
    localparam logic [5:0] ALU_SLTU = 6'd9;
    localparam logic [5:0] ALU_LUI  = 6'd10;
    localparam logic [5:0] ALU_LB   = 6'd16;
    localparam logic [5:0] ALU_LH   = 6'd17;
    localparam logic [5:0] ALU_LW   = 6'd18;
    localparam logic [5:0] ALU_LBU  = 6'd19;
    localparam logic [5:0] ALU_LHU  = 6'd20;
    localparam logic [5:0] ALU_SB   = 6'd21;
    localparam logic [5:0] ALU_SH   = 6'd22;
    localparam logic [5:0] ALU_SW   = 6'd23;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_REQ    = 2'd1,
        LSU_WAIT_R = 2'd2,
        LSU_WB     = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } acc_size_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_load(input logic [5:0] code);
        case (code)
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] code);
        case (code)
            ALU_SB, ALU_SH, ALU_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic acc_size_e acc_size(input logic [5:0] code);
        case (code)
            ALU_LB, ALU_LBU, ALU_SB: return SZ_BYTE;
            ALU_LH, ALU_LHU, ALU_SH: return SZ_HALF;
            ALU_LW, ALU_SW:          return SZ_WORD;
            default:                 return SZ_NONE;
        endcase
    endfunction

    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input acc_size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: return BE_BYTE << lane;
            SZ_HALF: return lane[1] ? (BE_HALF << 2'd2) : BE_HALF;
            SZ_WORD: return BE_WORD;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Selects the addressed byte/halfword lane of a returned load word and
// sign- or zero-extends it to the datapath width.
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      alucode,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ext_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rdata[{lane, 3'b000} +: 8];
    assign half_s = rdata[{lane[1], 4'b0000} +: 16];

    // Extend the selected lane according to the load flavour
    always_comb begin
        ext_data = rdata;
        case (alucode)
            ALU_LB:  ext_data = {{(XLEN-8){byte_s[7]}}, byte_s};
            ALU_LBU: ext_data = {{(XLEN-8){1'b0}}, byte_s};
            ALU_LH:  ext_data = {{(XLEN-16){half_s[15]}}, half_s};
            ALU_LHU: ext_data = {{(XLEN-16){1'b0}}, half_s};
            ALU_LW:  ext_data = rdata;
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: sits behind the ALU, issues aligned memory requests with
// a req/gnt/rvalid handshake and produces one registered writeback beat per op.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [5:0]        ex_alucode,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [4:0]        ex_rd,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              misalign_err
);

    lsu_state_e state_r, state_s;

    // registered outputs and latched op context
    logic              mem_req_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        mem_be_r;
    logic [XLEN-1:0]   mem_wdata_r;
    logic              wb_valid_r, wb_we_r, misalign_r;
    logic [4:0]        wb_rd_r, rd_r;
    logic [XLEN-1:0]   wb_data_r;
    logic [5:0]        op_r;
    logic [1:0]        lane_r;

    // next-cycle values
    logic              mem_req_nx_s, mem_we_nx_s;
    logic [ADDR_W-1:0] mem_addr_nx_s;
    logic [3:0]        mem_be_nx_s;
    logic [XLEN-1:0]   mem_wdata_nx_s;
    logic              wb_valid_nx_s, wb_we_nx_s, misalign_nx_s;
    logic [4:0]        wb_rd_nx_s, rd_nx_s;
    logic [XLEN-1:0]   wb_data_nx_s;
    logic [5:0]        op_nx_s;
    logic [1:0]        lane_nx_s;

    // decode of the op being offered
    logic              accept_s;
    logic              ex_is_mem_s, ex_is_store_s, ex_mis_s;
    acc_size_e         ex_size_s;
    logic [1:0]        ex_lane_s;
    logic [XLEN-1:0]   ex_wdata_s;
    logic [XLEN-1:0]   ext_s;

    assign ex_ready      = (state_r == LSU_IDLE) || (state_r == LSU_WB);
    assign accept_s      = ex_valid && ex_ready;
    assign ex_lane_s     = ex_result[1:0];
    assign ex_is_store_s = is_store(ex_alucode);
    assign ex_is_mem_s   = is_load(ex_alucode) || ex_is_store_s;
    assign ex_size_s     = acc_size(ex_alucode);
    assign ex_mis_s      = is_misaligned(ex_size_s, ex_lane_s);

    // Replicate store data across every lane it could land in
    always_comb begin
        ex_wdata_s = ex_store_data;
        case (ex_size_s)
            SZ_BYTE: ex_wdata_s = {(XLEN/8){ex_store_data[7:0]}};
            SZ_HALF: ex_wdata_s = {(XLEN/16){ex_store_data[15:0]}};
            default: ex_wdata_s = ex_store_data;
        endcase
    end

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .alucode  (op_r),
        .lane     (lane_r),
        .rdata    (mem_rdata),
        .ext_data (ext_s)
    );

    // Next-state and next-output logic; writeback strobes default low
    always_comb begin
        state_s        = state_r;
        mem_req_nx_s   = mem_req_r;
        mem_we_nx_s    = mem_we_r;
        mem_addr_nx_s  = mem_addr_r;
        mem_be_nx_s    = mem_be_r;
        mem_wdata_nx_s = mem_wdata_r;
        op_nx_s        = op_r;
        lane_nx_s      = lane_r;
        rd_nx_s        = rd_r;
        wb_valid_nx_s  = DISABLE;
        wb_we_nx_s     = DISABLE;
        misalign_nx_s  = DISABLE;
        wb_rd_nx_s     = wb_rd_r;
        wb_data_nx_s   = wb_data_r;
        case (state_r)
            LSU_IDLE, LSU_WB: begin
                if (accept_s) begin
                    if (!ex_is_mem_s) begin
                        state_s       = LSU_WB;
                        wb_valid_nx_s = ENABLE;
                        wb_we_nx_s    = (ex_rd != 5'd0);
                        wb_rd_nx_s    = ex_rd;
                        wb_data_nx_s  = ex_result;
                    end else if (ex_mis_s) begin
                        // misaligned accesses never reach memory
                        state_s       = LSU_WB;
                        wb_valid_nx_s = ENABLE;
                        misalign_nx_s = ENABLE;
                        wb_rd_nx_s    = ex_rd;
                        wb_data_nx_s  = {XLEN{1'b0}};
                    end else begin
                        state_s        = LSU_REQ;
                        mem_req_nx_s   = ENABLE;
                        mem_we_nx_s    = ex_is_store_s;
                        mem_addr_nx_s  = {ex_result[ADDR_W-1:2], 2'b00};
                        mem_be_nx_s    = lane_be(ex_size_s, ex_lane_s);
                        mem_wdata_nx_s = ex_wdata_s;
                        op_nx_s        = ex_alucode;
                        lane_nx_s      = ex_lane_s;
                        rd_nx_s        = ex_rd;
                    end
                end else begin
                    state_s = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                if (mem_gnt) begin
                    mem_req_nx_s = DISABLE;
                    if (mem_we_r) begin
                        state_s       = LSU_WB;
                        wb_valid_nx_s = ENABLE;
                        wb_rd_nx_s    = rd_r;
                    end else begin
                        state_s = LSU_WAIT_R;
                    end
                end else begin
                    state_s = LSU_REQ;
                end
            end
            LSU_WAIT_R: begin
                if (mem_rvalid) begin
                    state_s       = LSU_WB;
                    wb_valid_nx_s = ENABLE;
                    wb_we_nx_s    = (rd_r != 5'd0);
                    wb_rd_nx_s    = rd_r;
                    wb_data_nx_s  = ext_s;
                end else begin
                    state_s = LSU_WAIT_R;
                end
            end
            default: state_s = LSU_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Output and op-context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= {XLEN{1'b0}};
            op_r        <= 6'd0;
            lane_r      <= 2'd0;
            rd_r        <= 5'd0;
            wb_valid_r  <= 1'b0;
            wb_we_r     <= 1'b0;
            misalign_r  <= 1'b0;
            wb_rd_r     <= 5'd0;
            wb_data_r   <= {XLEN{1'b0}};
        end else begin
            mem_req_r   <= mem_req_nx_s;
            mem_we_r    <= mem_we_nx_s;
            mem_addr_r  <= mem_addr_nx_s;
            mem_be_r    <= mem_be_nx_s;
            mem_wdata_r <= mem_wdata_nx_s;
            op_r        <= op_nx_s;
            lane_r      <= lane_nx_s;
            rd_r        <= rd_nx_s;
            wb_valid_r  <= wb_valid_nx_s;
            wb_we_r     <= wb_we_nx_s;
            misalign_r  <= misalign_nx_s;
            wb_rd_r     <= wb_rd_nx_s;
            wb_data_r   <= wb_data_nx_s;
        end
    end

    assign mem_req      = mem_req_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_be       = mem_be_r;
    assign mem_wdata    = mem_wdata_r;
    assign wb_valid     = wb_valid_r;
    assign wb_we        = wb_we_r;
    assign wb_rd        = wb_rd_r;
    assign wb_data      = wb_data_r;
    assign misalign_err = misalign_r;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit. A small reference model computes
// memory requests and writeback beats from the op semantics; one compare
// process checks the DUT against it every cycle.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready;
    logic [5:0]  ex_alucode;
    logic [31:0] ex_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        mem_req, mem_gnt, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alucode(ex_alucode),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .misalign_err(misalign_err)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  rd;
        logic        mis;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    logic        exp_req_valid = 1'b0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_we;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [5:0] c);
        case (c)
            ALU_LB, ALU_LBU, ALU_SB: return 1;
            ALU_LH, ALU_LHU, ALU_SH: return 2;
            ALU_LW, ALU_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [5:0] c);
        return (c == ALU_SB) || (c == ALU_SH) || (c == ALU_SW);
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] c, input logic [31:0] a);
        int m;
        m = ((1 << op_size(c)) - 1) << int'(a % 32'd4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] c, input logic [31:0] d);
        case (op_size(c))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] c, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (a % 32'd4));
        case (op_size(c))
            1: begin
                v = v & 32'hFF;
                if (c == ALU_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            2: begin
                v = v & 32'hFFFF;
                if (c == ALU_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("reset_outputs",
                {mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_we, wb_rd, wb_data, misalign_err},
                128'd0);
        end else begin
            if (mem_req) begin
                if (!exp_req_valid) begin
                    chk("unexpected_mem_req", {127'd0, mem_req}, 128'd0);
                end else begin
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_be", mem_be, exp_be);
                    chk("mem_we", mem_we, exp_we);
                    if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
                end
            end
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb_valid", {127'd0, wb_valid}, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_cycle", cyc, e.cyc);
                    chk("wb_we", wb_we, e.we);
                    chk("misalign_err", misalign_err, e.mis);
                    if (e.we) chk("wb_rd", wb_rd, e.rd);
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op; returns in the cycle its writeback beat is visible.
    task automatic issue(input logic [5:0] code, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input int gnt_wait, input int rv_wait,
                         input logic [31:0] rdata);
        exp_t e;
        int   sz;
        bit   mis;
        sz  = op_size(code);
        mis = (sz != 0) && ((addr % sz) != 0);
        chk("ex_ready_accept", ex_ready, 1'b1);
        ex_valid = 1'b1; ex_alucode = code; ex_result = addr; ex_store_data = sd; ex_rd = rd;
        e.rd = rd; e.mis = 1'b0; e.we = 1'b0; e.chk_data = 1'b0; e.data = 32'd0;
        if (sz == 0 || mis) begin
            e.cyc = cyc + 1; e.mis = mis; e.we = !mis && (rd != 5'd0);
            e.chk_data = !mis; e.data = addr;
            exp_req_valid = 1'b0;
            exp_q.push_back(e);
            step();
            ex_valid = 1'b0;
        end else begin
            exp_req_valid = 1'b1;
            exp_addr  = addr & 32'hFFFF_FFFC;
            exp_be    = model_be(code, addr);
            exp_wdata = model_wdata(code, sd);
            exp_we    = op_store(code);
            step();
            ex_valid = 1'b0;
            for (int i = 0; i < gnt_wait; i++) begin
                chk("ex_ready_stall", ex_ready, 1'b0);
                chk("mem_req_held", mem_req, 1'b1);
                step();
            end
            mem_gnt = 1'b1;
            if (op_store(code)) begin
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            step();
            mem_gnt = 1'b0;
            exp_req_valid = 1'b0;
            chk("mem_req_drop", mem_req, 1'b0);
            if (!op_store(code)) begin
                for (int i = 0; i < rv_wait; i++) step();
                mem_rvalid = 1'b1; mem_rdata = rdata;
                e.cyc = cyc + 1; e.we = (rd != 5'd0); e.chk_data = 1'b1;
                e.data = model_load(code, addr, rdata);
                exp_q.push_back(e);
                step();
                mem_rvalid = 1'b0; mem_rdata = 32'hA5A5_5A5A;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_valid = 1'b0; ex_alucode = 6'd0; ex_result = 32'd0; ex_store_data = 32'd0; ex_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("idle_ready", ex_ready, 1'b1);
        step();

        // pass-through, then back-to-back with rd=0
        issue(ALU_ADD, 32'h0000_0042, 32'd0, 5'd5, 0, 0, 32'd0);
        chk("pass_data_lit", wb_data, 32'h42);
        chk("pass_we_lit", wb_we, 1'b1);
        issue(ALU_ADD, 32'h0000_0042, 32'd0, 5'd0, 0, 0, 32'd0);
        chk("pass_rd0_we_lit", wb_we, 1'b0);
        step();
        chk("wb_one_cycle_lit", wb_valid, 1'b0);

        // byte loads at lane 3
        issue(ALU_LB, 32'h0000_0103, 32'd0, 5'd7, 0, 0, 32'h80FF_1234);
        chk("lb_data_lit", wb_data, 32'hFFFF_FF80);
        chk("lb_addr_lit", mem_addr, 32'h0000_0100);
        chk("lb_be_lit", mem_be, 4'b1000);
        issue(ALU_LBU, 32'h0000_0103, 32'd0, 5'd7, 0, 0, 32'h80FF_1234);
        chk("lbu_data_lit", wb_data, 32'h0000_0080);

        // halfword store with grant delayed to c4
        issue(ALU_SH, 32'h0000_0202, 32'h1234_ABCD, 5'd3, 3, 0, 32'd0);
        chk("sh_be_lit", mem_be, 4'b1100);
        chk("sh_wdata_lit", mem_wdata, 32'hABCD_ABCD);
        chk("sh_we_lit", wb_we, 1'b0);

        // misaligned word load
        issue(ALU_LW, 32'h0000_0105, 32'd0, 5'd9, 0, 0, 32'd0);
        chk("lw_mis_lit", misalign_err, 1'b1);
        chk("lw_mis_we_lit", wb_we, 1'b0);
        chk("lw_mis_noreq_lit", mem_req, 1'b0);

        // more lanes, extensions and handshake timings
        issue(ALU_LH,  32'h0000_0002, 32'd0, 5'd10, 1, 2, 32'h8001_0000);
        chk("lh_data_lit", wb_data, 32'hFFFF_8001);
        issue(ALU_LHU, 32'h0000_0002, 32'd0, 5'd10, 0, 1, 32'h8001_0000);
        chk("lhu_data_lit", wb_data, 32'h0000_8001);
        issue(ALU_LW,  32'h0000_0010, 32'd0, 5'd0, 0, 0, 32'hDEAD_BEEF);
        chk("lw_data_lit", wb_data, 32'hDEAD_BEEF);
        issue(ALU_SB,  32'h0000_0301, 32'h0000_55AB, 5'd4, 2, 0, 32'd0);
        chk("sb_wdata_lit", mem_wdata, 32'hABAB_ABAB);
        chk("sb_be_lit", mem_be, 4'b0010);
        issue(ALU_SW,  32'h0000_0400, 32'hCAFE_F00D, 5'd6, 0, 0, 32'd0);
        issue(ALU_LH,  32'h0000_0003, 32'd0, 5'd11, 0, 0, 32'd0);
        issue(ALU_SH,  32'h0000_0001, 32'h1111_2222, 5'd12, 0, 0, 32'd0);
        issue(ALU_SW,  32'h0000_0402, 32'h3333_4444, 5'd13, 0, 0, 32'd0);
        issue(ALU_LB,  32'h0000_0007, 32'd0, 5'd14, 0, 0, 32'h7F00_0000);
        chk("lb_pos_lit", wb_data, 32'h0000_007F);
        issue(6'h3F,   32'hFFFF_FFFF, 32'd0, 5'd31, 0, 0, 32'd0);
        chk("unknown_pass_lit", wb_data, 32'hFFFF_FFFF);
        step();

        // stray gnt/rvalid while idle must do nothing
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        step();
        chk("stray_noreq_lit", mem_req, 1'b0);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        step();

        // reset while waiting for load data
        chk("ex_ready_before_rst", ex_ready, 1'b1);
        ex_valid = 1'b1; ex_alucode = ALU_LW; ex_result = 32'h0000_0500; ex_rd = 5'd4;
        exp_req_valid = 1'b1; exp_addr = 32'h0000_0500; exp_be = 4'b1111; exp_we = 1'b0;
        step();
        ex_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; exp_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset_lit",
            {mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_we, wb_rd, wb_data, misalign_err},
            128'd0);
        step();
        step();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_rvalid = 1'b0;
        step();
        chk("no_wb_after_rst_lit", wb_valid, 1'b0);
        chk("idle_after_rst_lit", ex_ready, 1'b1);

        issue(ALU_ADD, 32'h0000_0007, 32'd0, 5'd1, 0, 0, 32'd0);
        chk("post_rst_pass_lit", wb_data, 32'h7);
        step();
        step();

        chk("exp_queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
